// File: rtl/eth_tx_scheduler.sv
// Ethernet transmit scheduler: arbitrates ARP requests and UDP launches from
// the upload FIFO, waits for frame completion and enforces inter-frame gaps.
module eth_tx_scheduler #(
  parameter int unsigned PKT_LEN      = 1280,
  parameter int unsigned FLUSH_CYCLES = 125000,
  parameter int unsigned IFG_CYCLES   = 32,
  parameter int unsigned ARP_HOLD     = 128,
  parameter int unsigned ARP_RETRY    = 12500000,
  parameter int unsigned ARP_REFRESH  = 1250000000,
  parameter int unsigned TX_TIMEOUT   = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        arp_valid,
  input  logic [12:0] upl_rdusedw,
  input  logic        send_finish,
  output logic        arp_req,
  output logic        tx_data_en,
  output logic [15:0] tx_data_len,
  output logic        busy,
  output logic [31:0] pkt_cnt,
  output logic        timeout_err
);

  localparam int unsigned GAP_MAX = (IFG_CYCLES > ARP_HOLD) ? IFG_CYCLES : ARP_HOLD;
  localparam int unsigned GW = $clog2(GAP_MAX + 1);
  localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);
  localparam int unsigned WW = (TX_TIMEOUT > 2) ? $clog2(TX_TIMEOUT) : 1;

  localparam logic [12:0] PKT_LEN13 = 13'(PKT_LEN);
  localparam logic [15:0] PKT_LEN16 = 16'(PKT_LEN);
  localparam logic [FW-1:0] FLUSH_MAX = FW'(FLUSH_CYCLES);
  localparam logic [GW-1:0] IFG_LAST = GW'(IFG_CYCLES - 1);
  localparam logic [GW-1:0] HOLD_LAST = GW'(ARP_HOLD - 1);
  // Expiry is taken on the edge where the watchdog reaches TX_TIMEOUT-1, so
  // timeout_err shows up exactly TX_TIMEOUT cycles after the start pulse.
  localparam logic [WW-1:0] WD_LAST = WW'(TX_TIMEOUT - 2);
  // Reload is two short of the period: one cycle for the IDLE decision and
  // one for the pulse itself, so pulse-to-pulse spacing equals the period.
  localparam logic [31:0] RETRY_LD = 32'(ARP_RETRY - 2);
  localparam logic [31:0] REFRESH_LD = 32'(ARP_REFRESH - 2);

  typedef enum logic [2:0] {
    IDLE, ARP_TX, ARP_GAP, UDP_START, UDP_WAIT, IFG
  } state_t;

  state_t          state, state_n;
  logic [31:0]     arp_tmr;
  logic [FW-1:0]   flush_cnt;
  logic [WW-1:0]   wd_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            arp_valid_q;
  logic [15:0]     len_n;
  logic            tout_hit;

  // Next-state decision and the length to latch on a UDP launch.
  always_comb begin
    state_n  = state;
    len_n    = PKT_LEN16;
    tout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          if (arp_tmr == 32'd0) begin
            state_n = ARP_TX;
          end else if (arp_valid && upl_rdusedw >= PKT_LEN13) begin
            state_n = UDP_START;
            len_n   = PKT_LEN16;
          end else if (arp_valid && upl_rdusedw != 13'd0 && flush_cnt == FLUSH_MAX) begin
            state_n = UDP_START;
            len_n   = {3'b000, upl_rdusedw};
          end
        end
      end
      ARP_TX:    state_n = ARP_GAP;
      ARP_GAP:   if (gap_cnt == HOLD_LAST) state_n = IDLE;
      UDP_START: state_n = UDP_WAIT;
      UDP_WAIT: begin
        if (send_finish) begin
          state_n = IFG;
        end else if (wd_cnt == WD_LAST) begin
          state_n  = IFG;
          tout_hit = 1'b1;
        end
      end
      IFG:       if (gap_cnt == IFG_LAST) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // State register and registered outputs, decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      arp_req     <= 1'b0;
      tx_data_en  <= 1'b0;
      busy        <= 1'b0;
      tx_data_len <= 16'd0;
      pkt_cnt     <= 32'd0;
      timeout_err <= 1'b0;
    end else begin
      state      <= state_n;
      arp_req    <= (state_n == ARP_TX);
      tx_data_en <= (state_n == UDP_START);
      busy       <= (state_n != IDLE);
      if (state == IDLE && state_n == UDP_START) tx_data_len <= len_n;
      if (state == UDP_WAIT && send_finish) pkt_cnt <= pkt_cnt + 32'd1;
      if (tout_hit) timeout_err <= 1'b1;
    end
  end

  // ARP timer: free-running down-count; a lost MAC forces an immediate request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      arp_tmr     <= 32'd0;
      arp_valid_q <= 1'b0;
    end else begin
      arp_valid_q <= arp_valid;
      if (arp_valid_q && !arp_valid)  arp_tmr <= 32'd0;
      else if (state == ARP_TX)       arp_tmr <= arp_valid ? REFRESH_LD : RETRY_LD;
      else if (arp_tmr != 32'd0)      arp_tmr <= arp_tmr - 32'd1;
    end
  end

  // Flush counter: measures how long a short FIFO residue has sat idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush_cnt <= '0;
    end else if (upl_rdusedw == 13'd0 || state_n == UDP_START) begin
      flush_cnt <= '0;
    end else if (state == IDLE && upl_rdusedw < PKT_LEN13 && flush_cnt != FLUSH_MAX) begin
      flush_cnt <= flush_cnt + 1'b1;
    end
  end

  // Watchdog and gap counters; the gap counter restarts on every state change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt  <= '0;
      gap_cnt <= '0;
    end else begin
      if (state == UDP_WAIT) wd_cnt <= wd_cnt + 1'b1;
      else                   wd_cnt <= '0;
      if (state_n != state)                      gap_cnt <= '0;
      else if (state == ARP_GAP || state == IFG) gap_cnt <= gap_cnt + 1'b1;
    end
  end

endmodule

// File: doc/eth_tx_scheduler.md
Name: eth_tx_scheduler

Overview:
- Sequences the Ethernet transmit path. Decides when to fire an ARP request and when to launch a UDP packet drained from the upload FIFO.
- Issues one-cycle `arp_req` / `tx_data_en` pulses with a stable `tx_data_len`, waits for `send_finish`, and enforces an inter-frame gap.
- Blocks UDP until the destination MAC is resolved. Sits between the upload FIFO fill-level and the Ethernet top-level transmit controls.

Parameters:
- PKT_LEN, 1280: full UDP payload size in bytes.
- FLUSH_CYCLES, 125000: idle cycles with a partial FIFO before a short packet is flushed.
- IFG_CYCLES, 32: gap cycles after each UDP completion.
- ARP_HOLD, 128: gap cycles after each ARP request pulse.
- ARP_RETRY, 12500000: ARP request period while the MAC is unresolved.
- ARP_REFRESH, 1250000000: ARP request period while the MAC is resolved.
- TX_TIMEOUT, 65536: cycles allowed between `tx_data_en` and `send_finish`.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  scheduler enable. Low blocks new starts; an in-flight packet still completes.
- arp_valid  in  1  destination MAC resolved (from receive side).
- upl_rdusedw  in  13  upload FIFO read-side fill level, in bytes.
- send_finish  in  1  one-cycle pulse: UDP frame fully sent.
- arp_req  out  1  one-cycle ARP request pulse.
- tx_data_en  out  1  one-cycle UDP start pulse.
- tx_data_len  out  16  UDP payload length; stable from the `tx_data_en` pulse until the next start.
- busy  out  1  high in any state other than IDLE.
- pkt_cnt  out  32  completed UDP packets; wraps modulo 2^32.
- timeout_err  out  1  sticky; set on a `send_finish` watchdog expiry.

Behaviour:
- Reset (rst_n=0 at a clk edge, including mid-operation):
  - state=IDLE; all outputs 0; `pkt_cnt`=0; `timeout_err`=0.
  - ARP timer=0, so the first ARP fires on the first IDLE cycle with en=1.
  - Flush, watchdog and gap counters = 0.
- States: IDLE, ARP_TX, ARP_GAP, UDP_START, UDP_WAIT, IFG.
- IDLE, evaluated in priority order (only when en=1):
  1. ARP timer==0 -> ARP_TX.
  2. arp_valid=1 and upl_rdusedw>=PKT_LEN -> latch len=PKT_LEN -> UDP_START.
  3. arp_valid=1 and upl_rdusedw>0 and flush counter==FLUSH_CYCLES -> latch len={3'b0,upl_rdusedw} -> UDP_START.
- Flush counter:
  - Increments (saturating at FLUSH_CYCLES) in IDLE while 0<upl_rdusedw<PKT_LEN.
  - Clears when upl_rdusedw==0 or on entry to UDP_START.
- ARP_TX:
  - Lasts exactly 1 cycle; arp_req=1.
  - Reload ARP timer to ARP_REFRESH if arp_valid=1, else ARP_RETRY.
  - Go to ARP_GAP.
- ARP_GAP: count ARP_HOLD cycles, then IDLE.
- UDP_START:
  - Lasts exactly 1 cycle; tx_data_en=1.
  - tx_data_len is driven with the latched len in the same cycle (registered on IDLE exit).
  - Watchdog=0; go to UDP_WAIT.
- UDP_WAIT:
  - send_finish=1 -> pkt_cnt+1, go to IFG.
  - Otherwise, watchdog reaching TX_TIMEOUT-1 -> timeout_err=1 (sticky until reset), go to IFG; pkt_cnt unchanged.
  - If send_finish and expiry coincide, send_finish wins.
- IFG: count IFG_CYCLES cycles, then IDLE.
- send_finish outside UDP_WAIT is ignored.
- ARP timer:
  - 32-bit; decrements every cycle in every state, saturating at 0.
  - An ARP that becomes due during a packet or gap is deferred to the next IDLE cycle.
  - An arp_valid 1->0 transition forces the timer to 0 (immediate re-resolve); an in-flight packet still completes.
- en falling in a non-IDLE state: the current sequence completes normally; the block then stays in IDLE.
- Latency:
  - IDLE decision -> pulse: 1 cycle.
  - Minimum UDP-to-UDP spacing: 2 + wait + IFG_CYCLES cycles.
- Outputs are registered; no combinational input-to-output paths.

Test Plan (sim params: PKT_LEN=16, FLUSH_CYCLES=20, IFG_CYCLES=4, ARP_HOLD=3, ARP_RETRY=50, ARP_REFRESH=200, TX_TIMEOUT=30):
- Release reset with en=1, arp_valid=0 -> arp_req pulse on the first IDLE cycle. The next pulse follows 50 cycles after it. tx_data_en is never asserted even with upl_rdusedw=40.
- Set arp_valid=1, upl_rdusedw=40 -> after the pending ARP gap, tx_data_en pulses for 1 cycle with tx_data_len=16 and busy=1. Return send_finish 10 cycles later -> pkt_cnt=1; the next start comes no sooner than 4 cycles after finish.
- Hold upl_rdusedw=5 with arp_valid=1 -> tx_data_en fires with tx_data_len=5 after 20 idle cycles. Dropping upl_rdusedw to 0 at cycle 10 instead -> no start, flush counter clears.
- Withhold send_finish -> timeout_err=1 exactly 30 cycles after tx_data_en, pkt_cnt unchanged, block returns to IDLE after IFG. Apply reset -> timeout_err=0, pkt_cnt=0.
- ARP timer expires while in UDP_WAIT -> arp_req is deferred and pulses on the first IDLE cycle after IFG, taking priority over a ready UDP packet (upl_rdusedw=40).
- Deassert en during UDP_WAIT, then send_finish -> pkt_cnt increments, the block enters IDLE, and no further pulses occur until en=1. Drop arp_valid 1->0 -> arp_req on the next enabled IDLE cycle.
